// File: rtl/tri_raster_pkg.sv
// Shared types and helpers for the streaming triangle rasteriser.
// FSM encoding, edge-register width rule and bounding-box helpers.
package tri_raster_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_CORDW = 8;

  // Edge registers need two coordinate products plus sign and carry headroom.
  function automatic int ew_of(input int cordw);
    return 2 * cordw + 4;
  endfunction

  localparam int EW = ew_of(DEF_CORDW);

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tri_raster_stream_stepper.sv
// One incremental edge function of the rasteriser.
// Loads A, B and the bbox-origin value, then steps along x or rows.
module tri_edge_stepper #(
  parameter int CORDW = 8,
  parameter int EW    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_neg,
  input  logic [CORDW-1:0]       i_xa,
  input  logic [CORDW-1:0]       i_ya,
  input  logic [CORDW-1:0]       i_xb,
  input  logic [CORDW-1:0]       i_yb,
  input  logic [CORDW-1:0]       i_xmin,
  input  logic [CORDW-1:0]       i_ymin,
  input  logic                   i_step_x,
  input  logic                   i_new_row,
  output logic signed [EW-1:0]   o_e,
  output logic                   o_inside,
  output logic                   o_near
);

  localparam int DW = CORDW + 1;

  logic signed [DW-1:0] w_dx;
  logic signed [DW-1:0] w_dy;
  logic signed [DW-1:0] w_ox;
  logic signed [DW-1:0] w_oy;
  logic signed [EW-1:0] w_a;
  logic signed [EW-1:0] w_b;
  logic signed [EW-1:0] w_e0;
  logic signed [EW-1:0] w_absa;
  logic signed [EW-1:0] w_absb;

  logic signed [EW-1:0] r_a;
  logic signed [EW-1:0] r_b;
  logic signed [EW-1:0] r_e;
  logic signed [EW-1:0] r_row;

  // Coefficients and origin value; positive side is inside for CCW-positive area.
  always_comb begin
    w_dx = $signed({1'b0, i_xb}) - $signed({1'b0, i_xa});
    w_dy = $signed({1'b0, i_yb}) - $signed({1'b0, i_ya});
    w_ox = $signed({1'b0, i_xmin}) - $signed({1'b0, i_xa});
    w_oy = $signed({1'b0, i_ymin}) - $signed({1'b0, i_ya});
    w_a  = i_neg ? EW'(w_dy) : -EW'(w_dy);
    w_b  = i_neg ? -EW'(w_dx) : EW'(w_dx);
    w_e0 = w_a * EW'(w_ox) + w_b * EW'(w_oy);
  end

  // Edge state: load at setup, add A per x step, add B per row from row base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_e   <= '0;
      r_row <= '0;
    end else if (i_load) begin
      r_a   <= w_a;
      r_b   <= w_b;
      r_e   <= w_e0;
      r_row <= w_e0;
    end else if (i_new_row) begin
      r_e   <= r_row + r_b;
      r_row <= r_row + r_b;
    end else if (i_step_x) begin
      r_e   <= r_e + r_a;
    end
  end

  // Inside and one-pixel band tests on the current candidate.
  always_comb begin
    w_absa   = r_a[EW-1] ? -r_a : r_a;
    w_absb   = r_b[EW-1] ? -r_b : r_b;
    o_e      = r_e;
    o_inside = !r_e[EW-1];
    o_near   = (r_e < w_absa) || (r_e < w_absb);
  end

endmodule

// File: rtl/tri_raster_stream.sv
// Streaming triangle rasteriser: bbox walk, edge tests, valid/ready output.
// One candidate per clock, held under backpressure, with pixel counting.
module tri_raster_stream #(
  parameter int CORDW = 8,
  parameter int COLW  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CORDW-1:0]     x0,
  input  logic [CORDW-1:0]     y0,
  input  logic [CORDW-1:0]     x1,
  input  logic [CORDW-1:0]     y1,
  input  logic [CORDW-1:0]     x2,
  input  logic [CORDW-1:0]     y2,
  input  logic                 fill_enable,
  input  logic [COLW-1:0]      color,
  output logic                 busy,
  output logic [CORDW-1:0]     px,
  output logic [CORDW-1:0]     py,
  output logic [COLW-1:0]      pixel_color,
  output logic                 valid,
  input  logic                 ready,
  output logic [2*CORDW:0]     pix_count,
  output logic                 done
);

  import tri_raster_pkg::*;

  localparam int EWD = ew_of(CORDW);
  localparam int DW  = CORDW + 1;

  state_t r_state;
  state_t w_next;

  logic [CORDW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic             r_fill;
  logic [COLW-1:0]  r_col;
  logic [CORDW-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [CORDW-1:0] r_cx, r_cy;
  logic [CORDW-1:0] r_px, r_py;
  logic [COLW-1:0]  r_pcol;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [2*CORDW:0] r_cnt;

  logic signed [DW-1:0]  w_d1x, w_d1y, w_d2x, w_d2y;
  logic signed [EWD-1:0] w_area;
  logic                  w_neg;
  logic                  w_degen;
  logic [CORDW-1:0]      w_xmin, w_xmax, w_ymin, w_ymax;

  logic signed [EWD-1:0] w_e0, w_e1, w_e2;
  logic [2:0]            w_in;
  logic [2:0]            w_near;
  logic                  w_pass;

  logic w_accept;
  logic w_load;
  logic w_adv;
  logic w_eol;
  logic w_last;
  logic w_step_x;
  logic w_new_row;
  logic w_emit;
  logic w_take;

  // Setup geometry: signed doubled area and bounding box of latched vertices.
  always_comb begin
    w_d1x   = $signed({1'b0, r_x1}) - $signed({1'b0, r_x0});
    w_d1y   = $signed({1'b0, r_y1}) - $signed({1'b0, r_y0});
    w_d2x   = $signed({1'b0, r_x2}) - $signed({1'b0, r_x0});
    w_d2y   = $signed({1'b0, r_y2}) - $signed({1'b0, r_y0});
    w_area  = EWD'(w_d1x) * EWD'(w_d2y) - EWD'(w_d2x) * EWD'(w_d1y);
    w_neg   = w_area[EWD-1];
    w_degen = (w_area == '0);
    w_xmin  = CORDW'(min3(int'(r_x0), int'(r_x1), int'(r_x2)));
    w_xmax  = CORDW'(max3(int'(r_x0), int'(r_x1), int'(r_x2)));
    w_ymin  = CORDW'(min3(int'(r_y0), int'(r_y1), int'(r_y2)));
    w_ymax  = CORDW'(max3(int'(r_y0), int'(r_y1), int'(r_y2)));
  end

  tri_edge_stepper #(.CORDW(CORDW), .EW(EWD)) u_edge0 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_neg(w_neg),
    .i_xa(r_x0), .i_ya(r_y0), .i_xb(r_x1), .i_yb(r_y1),
    .i_xmin(w_xmin), .i_ymin(w_ymin),
    .i_step_x(w_step_x), .i_new_row(w_new_row),
    .o_e(w_e0), .o_inside(w_in[0]), .o_near(w_near[0])
  );

  tri_edge_stepper #(.CORDW(CORDW), .EW(EWD)) u_edge1 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_neg(w_neg),
    .i_xa(r_x1), .i_ya(r_y1), .i_xb(r_x2), .i_yb(r_y2),
    .i_xmin(w_xmin), .i_ymin(w_ymin),
    .i_step_x(w_step_x), .i_new_row(w_new_row),
    .o_e(w_e1), .o_inside(w_in[1]), .o_near(w_near[1])
  );

  tri_edge_stepper #(.CORDW(CORDW), .EW(EWD)) u_edge2 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_neg(w_neg),
    .i_xa(r_x2), .i_ya(r_y2), .i_xb(r_x0), .i_yb(r_y0),
    .i_xmin(w_xmin), .i_ymin(w_ymin),
    .i_step_x(w_step_x), .i_new_row(w_new_row),
    .o_e(w_e2), .o_inside(w_in[2]), .o_near(w_near[2])
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: w_next = w_degen ? S_DONE : S_SCAN;
      S_SCAN:  if (w_adv && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_valid || ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control decode: scan advances only when the output slot frees up.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && start;
    w_load    = (r_state == S_SETUP);
    w_adv     = (r_state == S_SCAN) && (!r_valid || ready);
    w_eol     = (r_cx == r_xmax);
    w_last    = w_eol && (r_cy == r_ymax);
    w_step_x  = w_adv && !w_eol;
    w_new_row = w_adv && w_eol && !w_last;
    w_pass    = (&w_in) && (r_fill || (|w_near));
    w_emit    = w_adv && w_pass;
    w_take    = r_valid && ready;
  end

  // Job latch and bounding-box walk counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0 <= '0; r_y0 <= '0;
      r_x1 <= '0; r_y1 <= '0;
      r_x2 <= '0; r_y2 <= '0;
      r_fill <= 1'b0;
      r_col  <= '0;
      r_xmin <= '0; r_xmax <= '0;
      r_ymin <= '0; r_ymax <= '0;
      r_cx   <= '0; r_cy   <= '0;
    end else if (w_accept) begin
      r_x0 <= x0; r_y0 <= y0;
      r_x1 <= x1; r_y1 <= y1;
      r_x2 <= x2; r_y2 <= y2;
      r_fill <= fill_enable;
      r_col  <= color;
    end else if (w_load) begin
      r_xmin <= w_xmin; r_xmax <= w_xmax;
      r_ymin <= w_ymin; r_ymax <= w_ymax;
      r_cx   <= w_xmin; r_cy   <= w_ymin;
    end else if (w_new_row) begin
      r_cx <= r_xmin;
      r_cy <= r_cy + CORDW'(1);
    end else if (w_step_x) begin
      r_cx <= r_cx + CORDW'(1);
    end
  end

  // Output slice: load on a passing candidate, clear once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px    <= '0;
      r_py    <= '0;
      r_pcol  <= '0;
      r_valid <= 1'b0;
    end else if (w_emit) begin
      r_px    <= r_cx;
      r_py    <= r_cy;
      r_pcol  <= r_col;
      r_valid <= 1'b1;
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

  // Job status: busy span, done pulse after DONE, handoff count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_accept)
        r_busy <= 1'b1;
      else if (r_state == S_DONE)
        r_busy <= 1'b0;
      if (w_accept)
        r_cnt <= '0;
      else if (w_take)
        r_cnt <= r_cnt + (2*CORDW+1)'(1);
    end
  end

  assign busy        = r_busy;
  assign px          = r_px;
  assign py          = r_py;
  assign pixel_color = r_pcol;
  assign valid       = r_valid;
  assign pix_count   = r_cnt;
  assign done        = r_done;

endmodule

// File: tb/tb_tri_raster_stream.sv
// Directed bench for tri_raster_stream: fill, outline, winding,
// backpressure, degenerate and mid-job reset cases.
module tb_tri_raster_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic        fill_enable = 1'b0;
  logic [23:0] color = '0;
  logic        busy;
  logic [7:0]  px, py;
  logic [23:0] pixel_color;
  logic        valid;
  logic        ready = 1'b1;
  logic [16:0] pix_count;
  logic        done;

  int total = 0;
  int bad   = 0;
  int ex[$];
  int ey[$];

  always #5 clk = ~clk;

  tri_raster_stream #(.CORDW(8), .COLW(24)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .fill_enable(fill_enable), .color(color),
    .busy(busy), .px(px), .py(py), .pixel_color(pixel_color),
    .valid(valid), .ready(ready), .pix_count(pix_count), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel list for the right triangle (0,0),(4,0),(0,4).
  task automatic build(input bit outline);
    ex.delete();
    ey.delete();
    for (int y = 0; y <= 4; y++)
      for (int x = 0; x <= 4; x++)
        if (x + y <= 4)
          if (!outline || x == 0 || y == 0 || x + y == 4) begin
            ex.push_back(x);
            ey.push_back(y);
          end
  endtask

  task automatic run_job(
    input string tag,
    input logic [7:0] ax0, input logic [7:0] ay0,
    input logic [7:0] ax1, input logic [7:0] ay1,
    input logic [7:0] ax2, input logic [7:0] ay2,
    input bit fill, input logic [23:0] col,
    input int stall_at, input int stall_len,
    input int exp_n, input bit chk_lat
  );
    int idx;
    int ndone;
    int done_at;
    int stall_rem;
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2;
    fill_enable = fill;
    color = col;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    idx = 0;
    ndone = 0;
    done_at = -1;
    stall_rem = stall_len;
    for (int c = 0; c < 60; c++) begin
      if (idx == stall_at && stall_rem > 0) begin
        ready = 1'b0;
        stall_rem--;
      end else begin
        ready = 1'b1;
      end
      if (!ready && idx < ex.size()) begin
        chk({tag, "_hold_v"}, 64'(valid), 64'd1);
        chk({tag, "_hold_x"}, 64'(px), 64'(ex[idx]));
        chk({tag, "_hold_y"}, 64'(py), 64'(ey[idx]));
      end
      if (valid && ready) begin
        if (idx < ex.size()) begin
          chk({tag, "_px"}, 64'(px), 64'(ex[idx]));
          chk({tag, "_py"}, 64'(py), 64'(ey[idx]));
          chk({tag, "_col"}, 64'(pixel_color), 64'(col));
        end else begin
          chk({tag, "_extra"}, 64'(idx), 64'(ex.size() - 1));
        end
        idx++;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      step();
    end
    ready = 1'b1;
    chk({tag, "_n"}, 64'(idx), 64'(exp_n));
    chk({tag, "_cnt"}, 64'(pix_count), 64'(exp_n));
    chk({tag, "_ndone"}, 64'(ndone), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    if (chk_lat)
      chk({tag, "_lat"}, 64'(done_at >= 0 && done_at <= 3), 64'd1);
  endtask

  initial begin
    step();
    step();
    step();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", 64'(pix_count), 64'd0);
    chk("rst_px", 64'({px, py}), 64'd0);
    rst = 1'b0;
    step();

    build(1'b0);
    run_job("T1", 0, 0, 4, 0, 0, 4, 1'b1, 24'h12ab34, -1, 0, 15, 1'b0);

    build(1'b1);
    run_job("T2", 0, 0, 4, 0, 0, 4, 1'b0, 24'h00ff00, -1, 0, 12, 1'b0);

    build(1'b0);
    run_job("T3", 0, 0, 0, 4, 4, 0, 1'b1, 24'hc0ffee, -1, 0, 15, 1'b0);

    run_job("T4", 0, 0, 4, 0, 0, 4, 1'b1, 24'h5a5a5a, 3, 5, 15, 1'b0);

    ex.delete();
    ey.delete();
    run_job("T5a", 0, 0, 2, 2, 4, 4, 1'b1, 24'h111111, -1, 0, 0, 1'b1);
    run_job("T5b", 3, 3, 3, 3, 3, 3, 1'b1, 24'h222222, -1, 0, 0, 1'b1);

    x0 = 0; y0 = 0; x1 = 4; y1 = 0; x2 = 0; y2 = 4;
    fill_enable = 1'b1;
    color = 24'h777777;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("T6_mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("T6_valid", 64'(valid), 64'd0);
    chk("T6_busy", 64'(busy), 64'd0);
    chk("T6_done", 64'(done), 64'd0);
    chk("T6_cnt", 64'(pix_count), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    build(1'b0);
    run_job("T6r", 0, 0, 4, 0, 0, 4, 1'b1, 24'h13579b, -1, 0, 15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
